// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: four-state multicycle sequencer for one register-to-register
// instruction. Reads two sources from an external regfile, drives an external
// ALU, and writes the result back, reporting carry/zero of the last completed
// instruction.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    // instruction handshake
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    // regfile read ports (combinational read)
    output logic [AW-1:0]    ra1,
    output logic [AW-1:0]    ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    // ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    // regfile write port
    output logic             regwrite,
    output logic [AW-1:0]    wa,
    output logic [WIDTH-1:0] wd,
    // status
    output logic             done,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

    state_e state_q, state_d;

    // Instruction fields latched at accept.
    logic [1:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;

    // Datapath registers.
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             zero_q;

    // Output holding registers: ALU function and write address are captured
    // on entry to their own state so they keep the previous instruction's
    // values until then, rather than tracking the freshly latched fields.
    logic [1:0]       f_q;
    logic [AW-1:0]    wa_q;

    logic             wr_blocked;

    // Hardwired r0: suppress the write, but the instruction still completes.
    assign wr_blocked = (ZERO_REG != 0) && (wa_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        regwrite    = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StExec;
            end
            StExec: begin
                state_d = StWrite;
            end
            StWrite: begin
                // Gated by reset so a reset during writeback cancels the write.
                done     = ~reset;
                regwrite = ~reset & ~wr_blocked;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath: field latch, operand fetch, result/flag capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            f_q     <= '0;
            wa_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rd_q  <= instr_rd;
                        rs1_q <= instr_rs1;
                        rs2_q <= instr_rs2;
                    end
                end
                StRead: begin
                    opa_q <= rd1;
                    opb_q <= rd2;
                    f_q   <= op_q;
                end
                StExec: begin
                    res_q   <= alu_y;
                    // op[1]==0 selects ADD/SUB; logic ops always clear carry.
                    carry_q <= ~op_q[1] & alu_cout;
                    zero_q  <= (alu_y == '0);
                    wa_q    <= rd_q;
                end
                StWrite: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Read addresses follow the latched sources, which only change at accept.
    assign ra1   = rs1_q;
    assign ra2   = rs2_q;
    assign alu_a = opa_q;
    assign alu_b = opb_q;
    assign alu_f = f_q;
    assign wa    = wa_q;
    assign wd    = res_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (ZERO_REG=0 and ZERO_REG=1) run the
// same instruction stream in lockstep, each with its own regfile and ALU.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [1:0] instr_op;
    logic [2:0] instr_rd, instr_rs1, instr_rs2;

    logic       ready0, ready1;
    logic [2:0] ra1_0, ra2_0, ra1_1, ra2_1;
    logic [7:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic [7:0] a0, b0, a1, b1, y0, y1;
    logic [1:0] f0, f1;
    logic       cout0, cout1;
    logic       regwrite0, regwrite1;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       done0, done1, carry0, carry1, zero0, zero1;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(8), .AW(3), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready0),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .ra1(ra1_0), .ra2(ra2_0), .rd1(rd1_0), .rd2(rd2_0),
        .alu_a(a0), .alu_b(b0), .alu_f(f0), .alu_y(y0), .alu_cout(cout0),
        .regwrite(regwrite0), .wa(wa0), .wd(wd0), .done(done0), .carry(carry0),
        .zero(zero0)
    );

    alu_seq_ctrl #(.WIDTH(8), .AW(3), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready1),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .ra1(ra1_1), .ra2(ra2_1), .rd1(rd1_1), .rd2(rd2_1),
        .alu_a(a1), .alu_b(b1), .alu_f(f1), .alu_y(y1), .alu_cout(cout1),
        .regwrite(regwrite1), .wa(wa1), .wd(wd1), .done(done1), .carry(carry1),
        .zero(zero1)
    );

    // Environment ALU. Logic ops drive cout=1 so a DUT that forwards it shows up.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] f);
        case (f)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} + {1'b0, ~b} + 9'd1;
            2'd2:    return {1'b1, a & b};
            default: return {1'b1, a | b};
        endcase
    endfunction

    assign {cout0, y0} = alu_fn(a0, b0, f0);
    assign {cout1, y1} = alu_fn(a1, b1, f1);

    // Environment regfiles with a backdoor preload port.
    logic [7:0] rf0 [8];
    logic [7:0] rf1 [8];
    logic       pl_en;
    logic [2:0] pl_addr;
    logic [7:0] pl_data;
    int         wcount0 = 0;
    int         wcount1 = 0;

    assign rd1_0 = rf0[ra1_0];
    assign rd2_0 = rf0[ra2_0];
    assign rd1_1 = rf1[ra1_1];
    assign rd2_1 = rf1[ra2_1];

    always @(posedge clk) begin
        if (pl_en) begin
            rf0[pl_addr] <= pl_data;
            rf1[pl_addr] <= pl_data;
        end
        if (regwrite0) begin
            rf0[wa0] <= wd0;
            wcount0  <= wcount0 + 1;
        end
        if (regwrite1) begin
            rf1[wa1] <= wd1;
            wcount1  <= wcount1 + 1;
        end
    end

    // Reference register state and flags per instance.
    int m0 [8];
    int m1 [8];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of one instruction in plain integer arithmetic.
    task automatic ref_exec(input int op, input int a, input int b,
                            output int res, output int c);
        case (op)
            0: begin res = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a >= b) ? 1 : 0;     end
            2: begin res = a & b;               c = 0;                    end
            default: begin res = a | b;         c = 0;                    end
        endcase
    endtask

    task automatic preload(input int addr, input int val);
        pl_en   = 1'b1;
        pl_addr = addr[2:0];
        pl_data = val[7:0];
        @(posedge clk); #1;
        pl_en   = 1'b0;
        m0[addr] = val;
        m1[addr] = val;
    endtask

    task automatic run_instr(input int op, input int rd, input int rs1, input int rs2,
                             input bit rst_in_write);
        int r0, c0, r1, c1;
        int old0, old1;
        ref_exec(op, m0[rs1], m0[rs2], r0, c0);
        ref_exec(op, m1[rs1], m1[rs2], r1, c1);
        old0 = m0[rd];
        old1 = m1[rd];
        check_eq("idle_ready0", ready0, 1);
        check_eq("idle_ready1", ready1, 1);
        instr_op    = op[1:0];
        instr_rd    = rd[2:0];
        instr_rs1   = rs1[2:0];
        instr_rs2   = rs2[2:0];
        instr_valid = 1'b1;
        @(posedge clk); #1;                       // accept edge E0 -> READ
        instr_valid = 1'b0;
        check_eq("read_ready", ready0, 0);
        check_eq("read_done", done0, 0);
        @(posedge clk); #1;                       // E1 -> EXEC
        check_eq("exec_done", done0, 0);
        check_eq("exec_alu_f", f0, op);
        check_eq("exec_alu_a", a0, m0[rs1]);
        check_eq("exec_alu_b", b1, m1[rs2]);
        @(posedge clk); #1;                       // E2 -> WRITE
        if (rst_in_write) begin
            reset = 1'b1;
            #1;
            check_eq("rstw_regwrite0", regwrite0, 0);
            check_eq("rstw_regwrite1", regwrite1, 0);
            check_eq("rstw_done", done0, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            check_eq("rstw_ready", ready0, 1);
            check_eq("rstw_carry", carry0, 0);
            check_eq("rstw_zero", zero0, 0);
            check_eq("rstw_dest0", rf0[rd], old0);
            check_eq("rstw_dest1", rf1[rd], old1);
            return;
        end
        check_eq("wr_done0", done0, 1);
        check_eq("wr_done1", done1, 1);
        check_eq("wr_regwrite0", regwrite0, 1);
        check_eq("wr_regwrite1", regwrite1, (rd != 0) ? 1 : 0);
        check_eq("wr_wa", wa0, rd);
        check_eq("wr_wd0", wd0, r0);
        check_eq("wr_wd1", wd1, r1);
        @(posedge clk); #1;                       // E3: write committed, IDLE
        m0[rd] = r0;
        if (rd != 0) m1[rd] = r1;
        check_eq("post_done", done0, 0);
        check_eq("post_ready", ready0, 1);
        check_eq("post_rf0", rf0[rd], m0[rd]);
        check_eq("post_rf1", rf1[rd], m1[rd]);
        check_eq("post_carry0", carry0, c0);
        check_eq("post_zero0", zero0, (r0 == 0) ? 1 : 0);
        check_eq("post_carry1", carry1, c1);
        check_eq("post_zero1", zero1, (r1 == 0) ? 1 : 0);
    endtask

    initial begin
        int w0, w1, r, c;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", ready0, 1);
        check_eq("rst_ra1", ra1_0, 0);
        check_eq("rst_wa", wa0, 0);
        check_eq("rst_wd", wd0, 0);
        check_eq("rst_alu_a", a0, 0);
        check_eq("rst_alu_f", f0, 0);
        check_eq("rst_flags", {carry0, zero0}, 0);
        check_eq("rst_strobes", {done0, regwrite0}, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) preload(i, 0);

        // 1: ADD wraps to zero with carry.
        preload(1, 8'hFF);
        preload(3, 8'h01);
        run_instr(0, 2, 1, 3, 1'b0);
        check_eq("t1_r2", rf0[2], 8'h00);
        check_eq("t1_flags", {carry0, zero0}, 2'b11);

        // 2: SUB equal then SUB with borrow.
        preload(1, 8'h05);
        preload(3, 8'h05);
        run_instr(1, 4, 1, 3, 1'b0);
        check_eq("t2a_flags", {carry0, zero0}, 2'b11);
        preload(3, 8'h06);
        run_instr(1, 4, 1, 3, 1'b0);
        check_eq("t2b_r4", rf0[4], 8'hFF);
        check_eq("t2b_flags", {carry0, zero0}, 2'b00);

        // 3: logic ops.
        preload(1, 8'hF0);
        preload(3, 8'h3C);
        run_instr(2, 5, 1, 3, 1'b0);
        check_eq("t3a_r5", rf0[5], 8'h30);
        run_instr(3, 5, 1, 3, 1'b0);
        check_eq("t3b_r5", rf0[5], 8'hFC);

        // 4: valid held high, one accept per four cycles.
        preload(1, 8'h11);
        preload(2, 8'h07);
        w0 = wcount0;
        w1 = wcount1;
        instr_op    = 2'd0;
        instr_rd    = 3'd2;
        instr_rs1   = 3'd1;
        instr_rs2   = 3'd2;
        instr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t4_ready0", ready0, (i % 4 == 0) ? 1 : 0);
            check_eq("t4_ready1", ready1, (i % 4 == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ref_exec(0, m0[2], m0[1], r, c);
            m0[2] = r;
            m1[2] = r;
        end
        check_eq("t4_writes0", wcount0 - w0, 4);
        check_eq("t4_writes1", wcount1 - w1, 4);
        check_eq("t4_r2", rf0[2], m0[2]);
        check_eq("t4_carry", carry0, c);
        check_eq("t4_ready_end", ready0, 1);

        // 5: reset during writeback cancels the write.
        preload(1, 8'h12);
        preload(3, 8'h34);
        run_instr(0, 6, 1, 3, 1'b1);

        // 6: hardwired r0 on the ZERO_REG=1 instance.
        w1 = wcount1;
        run_instr(0, 0, 1, 3, 1'b0);
        check_eq("t6_nowrite1", wcount1 - w1, 0);
        check_eq("t6_r0_1", rf1[0], 0);
        preload(1, 8'h40);
        run_instr(0, 1, 1, 1, 1'b0);
        check_eq("t6_r1_1", rf1[1], 8'h80);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            preload($urandom_range(1, 7), $urandom_range(0, 255));
            run_instr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
